instr_encoder_g7: RTL and testbench

- Encodes RV32I instruction descriptors (operation, registers, immediate) into 32-bit machine words. Covers the subset our control decoder handles: R-type, load, store and branch.
- Writes each word sequentially into the instruction-memory write port.
- Used by the self-test loader to build programs in IMEM before the core is released from reset.
- Input side uses a valid/ready handshake; output side is a single registered stage with memory back-pressure.

---
 rtl/instr_encoder_g7.sv | 156 +++++++++++++++
 tb/tb_instr_encoder_g7.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_g7.sv
// RV32I descriptor encoder (ADD/SUB/AND/OR/LW/SW/BEQ) feeding the IMEM write port.
// One registered output word with back-pressure; illegal descriptors are consumed and flagged.
module instr_encoder_g7 #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W:0]   word_count,
    output logic              wrapped,
    output logic              err_pulse,
    output logic              err_flag
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LW  = 3'd4,
        OP_SW  = 3'd5,
        OP_BEQ = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              wrapped_q, wrapped_d;
    logic              err_pulse_q, err_pulse_d;
    logic              err_flag_q, err_flag_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        imm_fits12;
    logic        accept;
    logic        complete;

    // I/S immediates are only legal when the 13-bit value sign-extends from bit 11
    always_comb begin
        enc_word   = 32'h0;
        enc_legal  = 1'b1;
        imm_fits12 = (in_imm[12] == in_imm[11]);
        case (op_e'(in_op))
            OP_ADD: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SUB: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_AND: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
            OP_OR:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
            OP_LW: begin
                enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
                enc_legal = imm_fits12;
            end
            OP_SW: begin
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
                enc_legal = imm_fits12;
            end
            OP_BEQ: begin
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], OPC_BR};
                enc_legal = ~in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        in_ready = ~reset & ~clear & (~wr_en_q | wr_ready);
        accept   = in_valid & in_ready;
        complete = wr_en_q & wr_ready;

        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        wrapped_d    = wrapped_q;
        err_pulse_d  = 1'b0;
        err_flag_d   = err_flag_q;

        if (complete) begin
            wr_en_d   = 1'b0;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == {ADDR_W{1'b1}}) wrapped_d = 1'b1;
            if (word_count_q != COUNT_MAX) word_count_d = word_count_q + (ADDR_W + 1)'(1);
        end

        // A completing word and a new accept in the same cycle reload without a bubble
        if (accept) begin
            if (enc_legal) begin
                wr_en_d   = 1'b1;
                wr_data_d = enc_word;
            end else begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
            end
        end

        if (clear) begin
            wr_en_d      = 1'b0;
            wr_addr_d    = '0;
            wr_data_d    = 32'h0;
            word_count_d = '0;
            wrapped_d    = 1'b0;
            err_pulse_d  = 1'b0;
            err_flag_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'h0;
            word_count_q <= '0;
            wrapped_q    <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            wrapped_q    <= wrapped_d;
            err_pulse_q  <= err_pulse_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;
    assign wrapped    = wrapped_q;
    assign err_pulse  = err_pulse_q;
    assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_instr_encoder_g7.sv
// Bench for instr_encoder_g7: directed scenarios plus a randomized run against a
// transaction-level model; a second instance with ADDR_W=2 exercises wrap and saturation.
module tb_instr_encoder_g7;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, wr_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;

    logic        a_in_ready, a_wr_en, a_wrapped, a_err_pulse, a_err_flag;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [8:0]  a_word_count;
    logic        b_in_ready, b_wr_en, b_wrapped, b_err_pulse, b_err_flag;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [2:0]  b_word_count;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    bit          m_pend, m_wrap, mb_wrap, m_errp, m_errf;
    logic [31:0] m_word;
    int          m_addr, m_cnt, mb_addr, mb_cnt;

    always #5 clk = ~clk;

    instr_encoder_g7 #(.ADDR_W(8)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_ready(wr_ready),
        .word_count(a_word_count), .wrapped(a_wrapped), .err_pulse(a_err_pulse),
        .err_flag(a_err_flag)
    );

    instr_encoder_g7 #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ready(wr_ready),
        .word_count(b_word_count), .wrapped(b_wrapped), .err_pulse(b_err_pulse),
        .err_flag(b_err_flag)
    );

    function automatic int signed_imm(input logic [12:0] imm);
        return (imm >= 13'd4096) ? int'(imm) - 8192 : int'(imm);
    endfunction

    function automatic bit ref_legal(input logic [2:0] op, input logic [12:0] imm);
        int s = signed_imm(imm);
        if (op == 3'd7) return 1'b0;
        if ((op == 3'd4 || op == 3'd5) && (s < -2048 || s > 2047)) return 1'b0;
        if (op == 3'd6 && (s % 2 != 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] op, input int rd, input int rs1,
                                            input int rs2, input logic [12:0] imm);
        int unsigned i = imm;
        int unsigned base = (rs1 << 15);
        case (op)
            3'd0: return base | (rs2 << 20) | (rd << 7) | 'h33;
            3'd1: return base | (32 << 25) | (rs2 << 20) | (rd << 7) | 'h33;
            3'd2: return base | (rs2 << 20) | (7 << 12) | (rd << 7) | 'h33;
            3'd3: return base | (rs2 << 20) | (6 << 12) | (rd << 7) | 'h33;
            3'd4: return base | ((i % 4096) << 20) | (2 << 12) | (rd << 7) | 'h03;
            3'd5: return base | (((i / 32) % 128) << 25) | (rs2 << 20) | (2 << 12)
                        | ((i % 32) << 7) | 'h23;
            3'd6: return base | (((i / 4096) % 2) << 31) | (((i / 32) % 64) << 25) | (rs2 << 20)
                        | (((i / 2) % 16) << 8) | (((i / 2048) % 2) << 7) | 'h63;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [2:0] op, input int rd, input int rs1,
                         input int rs2, input logic [12:0] imm);
        in_valid = v; in_op = op; in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    endtask

    // Advance one clock and the model with it; leaves time at posedge+1.
    task automatic tick();
        bit ready, comp, pend_n, errp_n, errf_n, wrap_n, wrapb_n;
        logic [31:0] word_n;
        int addr_n, cnt_n, addrb_n, cntb_n;
        #2;
        pend_n = m_pend; word_n = m_word; errp_n = 0; errf_n = m_errf;
        addr_n = m_addr; cnt_n = m_cnt; wrap_n = m_wrap;
        addrb_n = mb_addr; cntb_n = mb_cnt; wrapb_n = mb_wrap;
        if (reset || clear) begin
            pend_n = 0; word_n = 0; errf_n = 0; addr_n = 0; cnt_n = 0; wrap_n = 0;
            addrb_n = 0; cntb_n = 0; wrapb_n = 0;
        end else begin
            ready = !m_pend || wr_ready;
            comp  = m_pend && wr_ready;
            if (comp) begin
                pend_n = 0;
                addr_n = (m_addr + 1) % 256;  if (m_addr == 255) wrap_n = 1;
                addrb_n = (mb_addr + 1) % 4;  if (mb_addr == 3) wrapb_n = 1;
                cnt_n = (m_cnt < 256) ? m_cnt + 1 : 256;
                cntb_n = (mb_cnt < 4) ? mb_cnt + 1 : 4;
            end
            if (in_valid && ready) begin
                if (ref_legal(in_op, in_imm)) begin
                    pend_n = 1; word_n = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm);
                end else begin
                    errp_n = 1; errf_n = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_pend = pend_n; m_word = word_n; m_errp = errp_n; m_errf = errf_n;
        m_addr = addr_n; m_cnt = cnt_n; m_wrap = wrap_n;
        mb_addr = addrb_n; mb_cnt = cntb_n; mb_wrap = wrapb_n;
    endtask

    task automatic test_reset();
        reset = 1; clear = 0; wr_ready = 1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        #1;
        n_chk++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", a_in_ready); else n_pass++;
        tick();
        reset = 0;
        n_chk++; if (a_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b exp 0", a_wr_en); else n_pass++;
        n_chk++; if (a_wr_addr !== 8'd0) $display("FAIL rst_wr_addr got %0d exp 0", a_wr_addr); else n_pass++;
        n_chk++; if (a_wr_data !== 32'h0) $display("FAIL rst_wr_data got %h exp 0", a_wr_data); else n_pass++;
        n_chk++; if (a_word_count !== 9'd0) $display("FAIL rst_count got %0d exp 0", a_word_count); else n_pass++;
        n_chk++; if ({a_wrapped, a_err_pulse, a_err_flag} !== 3'b000)
            $display("FAIL rst_flags got %b exp 000", {a_wrapped, a_err_pulse, a_err_flag}); else n_pass++;
    endtask

    task automatic test_add();
        drive(1, 0, 3, 1, 2, 0);
        #1;
        n_chk++; if (a_in_ready !== 1'b1) $display("FAIL add_in_ready got %b exp 1", a_in_ready); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_chk++; if (a_wr_en !== 1'b1) $display("FAIL add_wr_en got %b exp 1", a_wr_en); else n_pass++;
        n_chk++; if (a_wr_addr !== 8'd0) $display("FAIL add_addr got %0d exp 0", a_wr_addr); else n_pass++;
        n_chk++; if (a_wr_data !== 32'h002081B3) $display("FAIL add_data got %h exp 002081b3", a_wr_data); else n_pass++;
        tick();
        n_chk++; if (a_word_count !== 9'd1) $display("FAIL add_count got %0d exp 1", a_word_count); else n_pass++;
        n_chk++; if (a_wr_en !== 1'b0) $display("FAIL add_idle got %b exp 0", a_wr_en); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [5]  = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        int          rds [5]  = '{3, 4, 5, 0, 0};
        int          r1s [5]  = '{1, 1, 2, 2, 1};
        int          r2s [5]  = '{2, 2, 0, 5, 2};
        logic [12:0] imms [5] = '{13'd0, 13'd0, 13'd8, 13'd12, 13'h1FF8};
        logic [31:0] exp [5]  = '{32'h402081B3, 32'h0020F233, 32'h00812283, 32'h00512623, 32'hFE208CE3};
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, ops[i], rds[i], r1s[i], r2s[i], imms[i]);
            #1;
            n_chk++; if (a_in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, a_in_ready); else n_pass++;
            tick();
            n_chk++; if (a_wr_en !== 1'b1 || a_wr_data !== exp[i] || a_wr_addr !== 8'(i))
                $display("FAIL b2b_word[%0d] got en=%b %h @%0d exp en=1 %h @%0d", i, a_wr_en, a_wr_data,
                         a_wr_addr, exp[i], i);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++; if (a_word_count !== 9'd5) $display("FAIL b2b_count got %0d exp 5", a_word_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        wr_ready = 0;
        drive(1, 0, 3, 1, 2, 0);
        tick();
        drive(1, 3, 7, 7, 7, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, a_in_ready); else n_pass++;
            tick();
            n_chk++; if (a_wr_en !== 1'b1 || a_wr_data !== 32'h002081B3 || a_wr_addr !== 8'd5)
                $display("FAIL bp_hold[%0d] got en=%b %h @%0d exp en=1 002081b3 @5", i, a_wr_en, a_wr_data, a_wr_addr);
            else n_pass++;
        end
        wr_ready = 1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++; if (a_wr_en !== 1'b0 || a_wr_addr !== 8'd6 || a_word_count !== 9'd6)
            $display("FAIL bp_release got en=%b @%0d cnt=%0d exp en=0 @6 cnt=6", a_wr_en, a_wr_addr, a_word_count);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [2:0]  ops [3]  = '{3'd7, 3'd4, 3'd6};
        logic [12:0] imms [3] = '{13'd0, 13'h0800, 13'd3};
        for (int i = 0; i < 3; i++) begin
            drive(1, ops[i], 1, 2, 3, imms[i]);
            #1;
            n_chk++; if (a_in_ready !== 1'b1) $display("FAIL ill_ready[%0d] got %b exp 1", i, a_in_ready); else n_pass++;
            tick();
            n_chk++; if (a_err_pulse !== 1'b1 || a_err_flag !== 1'b1 || a_wr_en !== 1'b0 || a_wr_addr !== 8'd6)
                $display("FAIL ill_reject[%0d] got p=%b f=%b en=%b @%0d exp p=1 f=1 en=0 @6", i,
                         a_err_pulse, a_err_flag, a_wr_en, a_wr_addr);
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++; if (a_err_pulse !== 1'b0 || a_err_flag !== 1'b1)
            $display("FAIL ill_sticky got p=%b f=%b exp p=0 f=1", a_err_pulse, a_err_flag); else n_pass++;
    endtask

    task automatic test_wrap();
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i + 1, 1, 2, 0);
            tick();
            n_chk++; if (b_wr_en !== 1'b1 || b_wr_addr !== 2'(i % 4) || b_wrapped !== (i == 4))
                $display("FAIL wrap_addr[%0d] got en=%b @%0d w=%b exp en=1 @%0d w=%b", i, b_wr_en,
                         b_wr_addr, b_wrapped, i % 4, (i == 4));
            else n_pass++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_chk++; if (b_word_count !== 3'd4) $display("FAIL wrap_sat got %0d exp 4", b_word_count); else n_pass++;
        n_chk++; if (a_word_count !== 9'd5 || a_wrapped !== 1'b0)
            $display("FAIL wrap_wide got cnt=%0d w=%b exp cnt=5 w=0", a_word_count, a_wrapped); else n_pass++;
    endtask

    task automatic test_clear();
        drive(1, 7, 0, 0, 0, 0);
        tick();
        wr_ready = 0;
        drive(1, 0, 3, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        clear = 1;
        #1;
        n_chk++; if (a_in_ready !== 1'b0) $display("FAIL clr_ready got %b exp 0", a_in_ready); else n_pass++;
        tick();
        clear = 0;
        n_chk++; if (a_wr_en !== 1'b0 || a_wr_addr !== 8'd0 || a_word_count !== 9'd0 || a_err_flag !== 1'b0)
            $display("FAIL clr_state got en=%b @%0d cnt=%0d f=%b exp all 0", a_wr_en, a_wr_addr, a_word_count, a_err_flag);
        else n_pass++;
        wr_ready = 1;
        drive(1, 0, 3, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n_chk++; if (a_wr_en !== 1'b1 || a_wr_addr !== 8'd0 || a_wr_data !== 32'h002081B3)
            $display("FAIL clr_after got en=%b @%0d %h exp en=1 @0 002081b3", a_wr_en, a_wr_addr, a_wr_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [12:0] imm;
        for (int c = 0; c < 400; c++) begin
            imm = 13'($urandom);
            if ($urandom_range(0, 1) == 0) imm = 13'(signed_imm(imm) / 4);
            drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), imm);
            wr_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 40) == 0);
            #1;
            n_chk++; if (a_in_ready !== (!clear && (!m_pend || wr_ready)) || b_in_ready !== a_in_ready)
                $display("FAIL rnd_ready[%0d] got a=%b b=%b exp %b", c, a_in_ready, b_in_ready,
                         (!clear && (!m_pend || wr_ready)));
            else n_pass++;
            tick();
            n_chk++; if (a_wr_en !== m_pend || (m_pend && a_wr_data !== m_word) || a_wr_addr !== 8'(m_addr))
                $display("FAIL rnd_word[%0d] got en=%b %h @%0d exp en=%b %h @%0d", c, a_wr_en, a_wr_data,
                         a_wr_addr, m_pend, m_word, m_addr);
            else n_pass++;
            n_chk++; if (a_word_count !== 9'(m_cnt) || a_wrapped !== m_wrap || a_err_pulse !== m_errp || a_err_flag !== m_errf)
                $display("FAIL rnd_stat[%0d] got cnt=%0d w=%b p=%b f=%b exp cnt=%0d w=%b p=%b f=%b", c,
                         a_word_count, a_wrapped, a_err_pulse, a_err_flag, m_cnt, m_wrap, m_errp, m_errf);
            else n_pass++;
            n_chk++; if (b_wr_en !== m_pend || b_wr_addr !== 2'(mb_addr) || b_word_count !== 3'(mb_cnt) || b_wrapped !== mb_wrap)
                $display("FAIL rnd_small[%0d] got en=%b @%0d cnt=%0d w=%b exp en=%b @%0d cnt=%0d w=%b", c,
                         b_wr_en, b_wr_addr, b_word_count, b_wrapped, m_pend, mb_addr, mb_cnt, mb_wrap);
            else n_pass++;
        end
        clear = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_wrap();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
